// File: rtl/jesd_link_sync_ctrl.sv
// -----------------------------------------------------------------------------
// jesd_link_sync_ctrl
//
// Link-sync controller between the ADC pin PHY and the JESD204B receive core.
// It brings SYSREF into the device-clock domain and keeps an LMFC counter
// aligned to it. It also collects per-lane code-group-sync status, drives
// SYNC~ towards the transmitter, and asks for a new sync when lane errors
// pile up while the link is carrying data.
//
// Parameters
//   NUM_LANES    number of JESD lanes (1..8)
//   LMFC_PERIOD  LMFC period in clk_i cycles (2..2**LMFC_W)
//   LMFC_W       LMFC counter width
//   SYNC_STAGES  SYSREF synchroniser depth (>=2)
//   SYSREF_MODE  0 = one-shot (armed capture), 1 = continuous realignment
//   ERR_THRESH   error cycles in DATA that force a resync (1..255)
//
// Ports
//   clk_i              in   device clock, all logic on the rising edge
//   rst_n_i            in   asynchronous active-low reset
//   sysref_i           in   SYSREF, asynchronous to clk_i
//   sysref_arm_i       in   pulse: arm one-shot capture, clear misalign flag
//   link_en_i          in   level: link enable
//   lane_cgs_done_i    in   per-lane CGS complete (level)
//   lane_err_i         in   per-lane error strobe
//   sync_n_o           out  SYNC~, low while sync is requested
//   lmfc_cnt_o         out  LMFC phase 0..LMFC_PERIOD-1
//   lmfc_edge_o        out  high while lmfc_cnt_o == 0
//   sysref_captured_o  out  sticky: a SYSREF edge has been accepted
//   sysref_misalign_o  out  sticky: an accepted edge was off the LMFC boundary
//   link_state_o       out  0 IDLE, 1 CGS, 2 WAIT_LMFC, 3 DATA
//   resync_cnt_o       out  error-triggered resyncs, saturating at 255
// -----------------------------------------------------------------------------
module jesd_link_sync_ctrl #(
    parameter int NUM_LANES   = 4,
    parameter int LMFC_PERIOD = 8,
    parameter int LMFC_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SYSREF_MODE = 0,
    parameter int ERR_THRESH  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 sysref_i,
    input  logic                 sysref_arm_i,
    input  logic                 link_en_i,
    input  logic [NUM_LANES-1:0] lane_cgs_done_i,
    input  logic [NUM_LANES-1:0] lane_err_i,
    output logic                 sync_n_o,
    output logic [LMFC_W-1:0]    lmfc_cnt_o,
    output logic                 lmfc_edge_o,
    output logic                 sysref_captured_o,
    output logic                 sysref_misalign_o,
    output logic [1:0]           link_state_o,
    output logic [7:0]           resync_cnt_o
);

    localparam logic [LMFC_W-1:0] LMFC_LAST = LMFC_W'(LMFC_PERIOD - 1);
    localparam logic [7:0]        ERR_LIM   = 8'(ERR_THRESH);
    localparam bit                ONE_SHOT  = (SYSREF_MODE == 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CGS       = 2'd1,
        WAIT_LMFC = 2'd2,
        DATA      = 2'd3
    } link_state_t;

    // Saturating 8-bit increment shared by the error and resync counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // -------------------------------------------------------------------------
    // Stage p0: SYSREF synchroniser chain and registered rising-edge detect
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sr_sync_p0;
    logic                   sr_prev_p1;
    logic                   sr_edge;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sr_sync_p0 <= '0;
            sr_prev_p1 <= 1'b0;
            sr_edge    <= 1'b0;
        end else begin
            sr_sync_p0 <= {sr_sync_p0[SYNC_STAGES-2:0], sysref_i};
            sr_prev_p1 <= sr_sync_p0[SYNC_STAGES-1];
            sr_edge    <= sr_sync_p0[SYNC_STAGES-1] & ~sr_prev_p1;
        end
    end

    // -------------------------------------------------------------------------
    // Stage p2: edge acceptance, LMFC counter and capture flags
    // -------------------------------------------------------------------------
    logic              armed;
    logic              accept;
    logic [LMFC_W-1:0] lmfc_cnt;
    logic [LMFC_W-1:0] lmfc_nat;
    logic              captured;
    logic              misalign;

    // An arm pulse coinciding with an edge re-arms instead of consuming the
    // edge, so software always gets a fresh capture after arming.
    assign accept   = sr_edge & (ONE_SHOT ? (armed & ~sysref_arm_i) : 1'b1);
    assign lmfc_nat = (lmfc_cnt == LMFC_LAST) ? '0 : lmfc_cnt + LMFC_W'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            armed    <= 1'b0;
            lmfc_cnt <= '0;
            captured <= 1'b0;
            misalign <= 1'b0;
        end else begin
            if (sysref_arm_i) begin
                armed <= 1'b1;
            end else if (accept) begin
                armed <= 1'b0;
            end

            lmfc_cnt <= accept ? '0 : lmfc_nat;
            captured <= captured | accept;

            // An edge landing exactly on the natural wrap is already aligned
            // and raises nothing; a new detection wins over a same-cycle clear.
            if (accept && captured && (lmfc_nat != '0)) begin
                misalign <= 1'b1;
            end else if (sysref_arm_i) begin
                misalign <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Link FSM with DATA-phase error counter
    // -------------------------------------------------------------------------
    link_state_t state, state_nxt;
    logic [7:0]  err_cnt, err_nxt;
    logic [7:0]  resync_cnt;
    logic        resync_inc;
    logic        all_done;
    logic        any_err;
    logic        err_hit;

    assign all_done = &lane_cgs_done_i;
    assign any_err  = |lane_err_i;
    assign err_hit  = (err_cnt >= ERR_LIM);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            err_cnt    <= 8'd0;
            resync_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            err_cnt <= err_nxt;
            if (resync_inc) begin
                resync_cnt <= sat_inc8(resync_cnt);
            end
        end
    end

    // The error counter only holds a value while the link stays in DATA, so
    // it is automatically zero on every DATA entry.
    always_comb begin
        state_nxt  = state;
        err_nxt    = 8'd0;
        resync_inc = 1'b0;
        if (!link_en_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = CGS;
                end
                CGS: begin
                    if (all_done && captured) begin
                        state_nxt = WAIT_LMFC;
                    end
                end
                WAIT_LMFC: begin
                    // Lane loss beats a coincident LMFC boundary.
                    if (!all_done) begin
                        state_nxt = CGS;
                    end else if (lmfc_cnt == '0) begin
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (err_hit) begin
                        state_nxt  = CGS;
                        resync_inc = 1'b1;
                    end else if (!all_done) begin
                        state_nxt = CGS;
                    end else begin
                        err_nxt = any_err ? sat_inc8(err_cnt) : err_cnt;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign sync_n_o          = (state == DATA);
    assign link_state_o      = state;
    assign lmfc_cnt_o        = lmfc_cnt;
    assign lmfc_edge_o       = (lmfc_cnt == '0);
    assign sysref_captured_o = captured;
    assign sysref_misalign_o = misalign;
    assign resync_cnt_o      = resync_cnt;

endmodule

// File: tb/tb_jesd_link_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jesd_link_sync_ctrl
//
// Directed bench for jesd_link_sync_ctrl. Two instances share all inputs:
// u_os uses one-shot SYSREF capture, u_ct uses continuous realignment.
// Inputs change 1 time unit after a rising edge and outputs are sampled there;
// "cyc" counts rising edges since the last reset release.
// -----------------------------------------------------------------------------
module tb_jesd_link_sync_ctrl;

    logic       clk;
    logic       rst_n;
    logic       sysref;
    logic       sysref_arm;
    logic       link_en;
    logic [3:0] lane_cgs_done;
    logic [3:0] lane_err;

    logic       os_sync_n, os_edge, os_cap, os_mis;
    logic [7:0] os_cnt, os_resync;
    logic [1:0] os_state;
    logic       ct_sync_n, ct_edge, ct_cap, ct_mis;
    logic [7:0] ct_cnt, ct_resync;
    logic [1:0] ct_state;

    int checks;
    int errors;
    int cyc;

    jesd_link_sync_ctrl #(
        .NUM_LANES(4), .LMFC_PERIOD(8), .LMFC_W(8),
        .SYNC_STAGES(2), .SYSREF_MODE(0), .ERR_THRESH(4)
    ) u_os (
        .clk_i(clk), .rst_n_i(rst_n), .sysref_i(sysref), .sysref_arm_i(sysref_arm),
        .link_en_i(link_en), .lane_cgs_done_i(lane_cgs_done), .lane_err_i(lane_err),
        .sync_n_o(os_sync_n), .lmfc_cnt_o(os_cnt), .lmfc_edge_o(os_edge),
        .sysref_captured_o(os_cap), .sysref_misalign_o(os_mis),
        .link_state_o(os_state), .resync_cnt_o(os_resync)
    );

    jesd_link_sync_ctrl #(
        .NUM_LANES(4), .LMFC_PERIOD(8), .LMFC_W(8),
        .SYNC_STAGES(2), .SYSREF_MODE(1), .ERR_THRESH(4)
    ) u_ct (
        .clk_i(clk), .rst_n_i(rst_n), .sysref_i(sysref), .sysref_arm_i(sysref_arm),
        .link_en_i(link_en), .lane_cgs_done_i(lane_cgs_done), .lane_err_i(lane_err),
        .sync_n_o(ct_sync_n), .lmfc_cnt_o(ct_cnt), .lmfc_edge_o(ct_edge),
        .sysref_captured_o(ct_cap), .sysref_misalign_o(ct_mis),
        .link_state_o(ct_state), .resync_cnt_o(ct_resync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic check_reset_os(input string tag);
        check({tag, "_sync_n"}, os_sync_n, 0);
        check({tag, "_cnt"},    os_cnt,    0);
        check({tag, "_edge"},   os_edge,   1);
        check({tag, "_cap"},    os_cap,    0);
        check({tag, "_mis"},    os_mis,    0);
        check({tag, "_state"},  os_state,  0);
        check({tag, "_resync"}, os_resync, 0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        sysref        = 1'b0;
        sysref_arm    = 1'b0;
        link_en       = 1'b0;
        lane_cgs_done = 4'h0;
        lane_err      = 4'h0;

        // ---------------- reset values
        repeat (3) tick();
        check_reset_os("rst");
        check("rst_ct_sync_n", ct_sync_n, 0);
        check("rst_ct_state",  ct_state,  0);

        // ---------------- one-shot instance: unarmed SYSREF is ignored
        rst_n         = 1'b1;
        cyc           = 0;
        link_en       = 1'b1;
        lane_cgs_done = 4'hF;
        check("rel_cnt0", os_cnt, 0);
        tick();
        check("idle_to_cgs", os_state, 1);
        check("cnt_e1", os_cnt, 1);
        sysref = 1'b1;
        run_to(3);
        sysref = 1'b0;
        for (int n = 4; n <= 9; n++) begin
            run_to(n);
            check("free_run", os_cnt, n % 8);
        end
        check("noarm_cap", os_cap, 0);
        check("noarm_stay_cgs", os_state, 1);

        // ---------------- arm, SYSREF rises in cycle 10
        sysref_arm = 1'b1;
        run_to(10);
        sysref_arm = 1'b0;
        check("arm_cnt", os_cnt, 2);
        sysref = 1'b1;
        run_to(12);
        sysref = 1'b0;
        run_to(13);
        check("pre_align_cnt", os_cnt, 5);
        check("pre_align_cap", os_cap, 0);
        run_to(14);
        check("align_cnt", os_cnt, 0);
        check("align_cap", os_cap, 1);
        check("align_mis", os_mis, 0);
        check("align_state", os_state, 1);
        run_to(15);
        check("wait_state", os_state, 2);
        check("wait_cnt", os_cnt, 1);
        check("wait_sync_n", os_sync_n, 0);

        // second edge without re-arm must not move the phase
        run_to(16);
        sysref = 1'b1;
        run_to(17);
        sysref = 1'b0;
        run_to(20);
        check("ignored_edge_cnt", os_cnt, 6);
        check("ignored_edge_mis", os_mis, 0);
        run_to(22);
        check("lmfc0_cnt", os_cnt, 0);
        check("lmfc0_edge", os_edge, 1);
        check("lmfc0_state", os_state, 2);
        check("lmfc0_sync_n", os_sync_n, 0);
        run_to(23);
        check("data_state", os_state, 3);
        check("data_sync_n", os_sync_n, 1);
        check("data_cnt", os_cnt, 1);

        // ---------------- four error cycles with two lanes flagged
        lane_err = 4'b0101;
        run_to(27);
        lane_err = 4'b0000;
        check("err4_state", os_state, 3);
        check("err4_resync", os_resync, 0);
        run_to(28);
        check("err_resync_state", os_state, 1);
        check("err_resync_sync_n", os_sync_n, 0);
        check("err_resync_cnt", os_resync, 1);
        run_to(29);
        check("relock_wait", os_state, 2);
        check("relock_cnt", os_cnt, 7);
        run_to(31);
        check("relock_data", os_state, 3);

        // ---------------- lane drop together with link disable
        lane_cgs_done = 4'b1011;
        link_en       = 1'b0;
        run_to(32);
        check("dis_state", os_state, 0);
        check("dis_resync", os_resync, 1);
        check("dis_sync_n", os_sync_n, 0);

        // ---------------- lane drop on the LMFC boundary in WAIT_LMFC
        link_en       = 1'b1;
        lane_cgs_done = 4'hF;
        run_to(34);
        check("rewait_state", os_state, 2);
        run_to(38);
        check("bnd_edge", os_edge, 1);
        check("bnd_state", os_state, 2);
        lane_cgs_done = 4'b1110;
        run_to(39);
        check("drop_beats_edge", os_state, 1);
        lane_cgs_done = 4'hF;
        run_to(40);
        check("rewait2_state", os_state, 2);
        run_to(47);
        check("redata_state", os_state, 3);

        // ---------------- asynchronous reset in DATA
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_os("async_rst");

        // ---------------- continuous instance
        tick();
        rst_n = 1'b1;
        cyc   = 0;
        run_to(4);
        sysref = 1'b1;
        run_to(5);
        sysref = 1'b0;
        run_to(8);
        check("ct_align_cnt", ct_cnt, 0);
        check("ct_align_cap", ct_cap, 1);
        check("ct_align_mis", ct_mis, 0);
        run_to(9);
        check("ct_wait_state", ct_state, 2);
        run_to(17);
        check("ct_data_state", ct_state, 3);
        check("ct_data_sync_n", ct_sync_n, 1);
        run_to(20);
        sysref = 1'b1;
        run_to(21);
        sysref = 1'b0;
        run_to(24);
        check("ct_onwrap_cnt", ct_cnt, 0);
        check("ct_onwrap_mis", ct_mis, 0);
        check("ct_onwrap_state", ct_state, 3);
        run_to(39);
        sysref = 1'b1;
        run_to(40);
        sysref = 1'b0;
        run_to(42);
        check("ct_pre_shift_cnt", ct_cnt, 2);
        check("ct_pre_shift_mis", ct_mis, 0);
        run_to(43);
        check("ct_shift_cnt", ct_cnt, 0);
        check("ct_shift_mis", ct_mis, 1);
        check("ct_shift_state", ct_state, 3);
        check("ct_shift_sync_n", ct_sync_n, 1);
        run_to(44);
        check("ct_post_cnt", ct_cnt, 1);
        sysref_arm = 1'b1;
        run_to(45);
        sysref_arm = 1'b0;
        check("ct_arm_clr_mis", ct_mis, 0);
        check("ct_arm_cnt", ct_cnt, 2);
        check("ct_arm_cap", ct_cap, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
